// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and channel state type for the
// interrupt timer bank.
package timer_pkg;

  localparam logic [3:0] GLOBAL_CH = 4'hF;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CMP    = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] GREG_PENDING = 2'd0;
  localparam logic [1:0] GREG_ENABLED = 2'd1;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IE       = 2;
  localparam int CTRL_PRE_LSB  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: prescaler, up-counter with compare, one-shot/periodic
// state machine and sticky pending flag, plus its register read value.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [1:0]       reg_sel_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ack_i,
  output logic             pend_o,
  output logic             ie_o,
  output logic [WIDTH-1:0] rdata_o
);

  ch_state_e              state_q;
  logic                   periodic_q;
  logic                   ie_q;
  logic                   pend_q;
  logic [PRE_W-1:0]       prescale_q;
  logic [PRE_W-1:0]       pre_cnt_q;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       cmp_q;

  logic                   running;
  logic                   tick;
  logic                   match;
  logic                   w1c;
  logic [PRE_W-1:0]       wr_prescale;
  logic [CTRL_PRE_LSB+PRE_W-1:0] ctrl_rd;

  assign running     = (state_q == RUN);
  assign tick        = running && (pre_cnt_q == prescale_q);
  assign match       = tick && (count_q == cmp_q);
  assign w1c         = wr_en_i && (reg_sel_i == REG_STATUS) && wdata_i[0];
  assign wr_prescale = PRE_W'(wdata_i >> CTRL_PRE_LSB);

  assign pend_o = pend_q;
  assign ie_o   = ie_q;

  // EN is not stored separately: it reads back as "currently in RUN".
  always_comb begin
    ctrl_rd                             = '0;
    ctrl_rd[CTRL_EN]                    = running;
    ctrl_rd[CTRL_PERIODIC]              = periodic_q;
    ctrl_rd[CTRL_IE]                    = ie_q;
    ctrl_rd[CTRL_PRE_LSB +: PRE_W]      = prescale_q;
  end

  always_comb begin
    case (reg_sel_i)
      REG_CTRL:  rdata_o = WIDTH'(ctrl_rd);
      REG_COUNT: rdata_o = count_q;
      REG_CMP:   rdata_o = cmp_q;
      default:   rdata_o = WIDTH'(pend_q);
    endcase
  end

  // Software writes are applied last so they override the hardware update;
  // a match sets PEND even when cleared on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
      pend_q     <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      count_q    <= '0;
      cmp_q      <= '0;
    end else begin
      if (running) pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) count_q <= match ? '0 : count_q + 1'b1;
      if (match && !periodic_q) state_q <= DONE;

      if (match) pend_q <= 1'b1;
      else if (ack_i || w1c) pend_q <= 1'b0;

      if (wr_en_i) begin
        case (reg_sel_i)
          REG_CTRL: begin
            state_q    <= wdata_i[CTRL_EN] ? RUN : IDLE;
            periodic_q <= wdata_i[CTRL_PERIODIC];
            ie_q       <= wdata_i[CTRL_IE];
            prescale_q <= wr_prescale;
            pre_cnt_q  <= '0;
          end
          REG_COUNT: count_q <= wdata_i;
          REG_CMP:   cmp_q   <= wdata_i;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: rtl/irq_timer_bank.sv
// Bank of NUM_CH interrupt timers behind a small register port, with one
// prioritised (lowest index wins) registered interrupt request and ack.
module irq_timer_bank
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int PRE_W  = 8,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [7:0]       addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  input  logic             irq_ack_i
);

  logic [3:0]        ch_sel;
  logic [1:0]        reg_sel;
  logic [NUM_CH-1:0] pend_vec;
  logic [NUM_CH-1:0] ie_vec;
  logic [NUM_CH-1:0] active_vec;
  logic [WIDTH-1:0]  ch_rdata [NUM_CH];
  logic              irq_q;
  logic [ID_W-1:0]   irq_id_q;
  logic              prio_any;
  logic [ID_W-1:0]   prio_id;
  logic              unused_addr;

  assign ch_sel      = addr_i[7:4];
  assign reg_sel     = addr_i[3:2];
  assign unused_addr = ^addr_i[1:0];
  assign active_vec  = pend_vec & ie_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    logic ack_sel;
    assign wr_sel  = wr_en_i && (ch_sel == 4'(i));
    assign ack_sel = irq_ack_i && irq_q && (irq_id_q == ID_W'(i));

    timer_channel #(
      .WIDTH (WIDTH),
      .PRE_W (PRE_W)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (wr_sel),
      .reg_sel_i (reg_sel),
      .wdata_i   (wdata_i),
      .ack_i     (ack_sel),
      .pend_o    (pend_vec[i]),
      .ie_o      (ie_vec[i]),
      .rdata_o   (ch_rdata[i])
    );
  end

  // Scan downwards so the lowest pending index is the last one assigned.
  always_comb begin
    prio_any = 1'b0;
    prio_id  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (active_vec[i]) begin
        prio_any = 1'b1;
        prio_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rd_en_i) begin
      if (ch_sel == GLOBAL_CH) begin
        case (reg_sel)
          GREG_PENDING: rdata_o = WIDTH'(pend_vec);
          GREG_ENABLED: rdata_o = WIDTH'(active_vec);
          default:      rdata_o = '0;
        endcase
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_sel == 4'(i)) rdata_o = ch_rdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      irq_q <= prio_any;
      if (prio_any) irq_id_q <= prio_id;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: doc/irq_timer_bank.md
# irq_timer_bank

Parametrised multi-channel interrupt timer that replaces the single free-running timer feeding the CSR trap input. Each of NUM_CH channels has a prescaler, a WIDTH-bit up-counter, a compare register and one-shot/periodic modes. Channels are programmed through a memory-mapped register port driven from the data-memory address decode. The block presents one prioritised interrupt request with a channel ID, and the trap-return path acknowledges it.

## Interface
- NUM_CH, 4: number of timer channels, 1..15.
- WIDTH, 32: counter, compare and data-bus width, 8..32.
- PRE_W, 8: prescaler field width.
- ID_W, $clog2(NUM_CH) (min 1): width of irq_id.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  register write strobe, one cycle.
- rd_en  in  1  register read strobe.
- addr  in  8  byte address. addr[7:4] selects the channel, with 4'hF selecting the global registers. addr[3:2] selects the register. addr[1:0] is ignored.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data; combinational.
- irq  out  1  registered interrupt request.
- irq_id  out  ID_W  registered ID of the lowest-numbered pending and enabled channel.
- irq_ack  in  1  one-cycle pulse that clears pending for the channel on irq_id.

## Operation
- Per-channel registers:
  - reg0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IE, bits[8+PRE_W-1:8] PRESCALE.
  - reg1 COUNT: read/write.
  - reg2 CMP: read/write.
  - reg3 STATUS: bit0 PEND, write-1-to-clear.
- Global registers:
  - reg0 PENDING[NUM_CH-1:0]: read-only.
  - reg1 ENABLED_IRQ = PEND & IE: read-only.
  - Other global offsets read 0; writes to them are ignored.
- Channel index >= NUM_CH (other than 4'hF): reads return 0, writes are ignored.
- rdata is 0 whenever rd_en=0.
- Channel state machine:
  - IDLE: EN=0. Counter and prescaler are frozen.
  - RUN: entered when EN is written to 1.
  - DONE: one-shot expiry.
  - RUN→DONE: on a one-shot match. Hardware clears EN.
  - DONE→RUN: on a software write with EN=1.
  - Any state→IDLE: on a write with EN=0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE while in RUN. tick = (pre_cnt==PRESCALE), after which pre_cnt returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - Any CTRL write clears pre_cnt.
- Counter:
  - On a tick with COUNT==CMP: match. PEND←1 and COUNT←0, in both modes.
  - On a tick with COUNT!=CMP: COUNT←COUNT+1, wrapping modulo 2^WIDTH.
  - Period = (CMP+1)·(PRESCALE+1) cycles.
- Interrupt output:
  - irq ← |(PEND & IE), registered.
  - irq_id ← lowest index i with PEND[i]&IE[i], registered. Holds its previous value when none is pending.
- Acknowledge: irq_ack with irq=1 clears PEND[irq_id]. irq_ack with irq=0 is ignored.

## Timing
- Reset values: all CTRL/COUNT/CMP/PEND = 0, pre_cnt = 0, every channel in IDLE, irq = 0, irq_id = 0.
- Writes take effect at the clock edge on which wr_en is sampled. Reads are same-cycle.
- Latency from a match tick to PEND visible: 1 edge. From the match tick to irq asserted: 2 edges.
- After irq_ack: PEND clears at that edge and irq deasserts at the next edge, unless another channel is still pending. In that case irq stays 1 and irq_id updates.
- Simultaneous events:
  - Software write to COUNT on a tick cycle: the write wins.
  - W1C or irq_ack on the same cycle as a new match for that channel: the set wins, so PEND stays 1.
  - Write of EN=0 on a match cycle: PEND is still set, then the channel goes IDLE.
  - CMP written below the current COUNT: the counter runs until it wraps through 2^WIDTH, then matches.
- Asynchronous reset asserted mid-count: all state clears immediately. Counting resumes only after EN is rewritten.

## Structure
- Package timer_pkg holds:
  - register offsets (CTRL/COUNT/CMP/STATUS, GLOBAL_CH=4'hF);
  - CTRL bit positions;
  - the channel-state enum {IDLE, RUN, DONE}.
- Sub-module timer_channel, instantiated NUM_CH times in a generate loop. It contains the prescaler, counter, compare logic, state machine and PEND flag, and exposes pend/ie plus the register read value.
- The top level holds address decode, the read mux, the priority encoder and the irq/irq_id/ack registers.

## Test plan
- Reset, then read every register: all return 0; irq=0, irq_id=0.
- Ch0: CMP=3, PRESCALE=0, CTRL=EN|PERIODIC|IE → PEND set every 4 cycles, irq first rises 2 edges after the match tick, COUNT sequence 0,1,2,3,0.
- Ch1 one-shot: CMP=2, PRESCALE=1 → a single match after 6 cycles, EN reads 0, state DONE, COUNT held at 0, no further PEND after W1C.
- Ch1 and ch2 expire on the same cycle, both with IE=1 → irq_id=1. After irq_ack, irq stays 1 and irq_id=2. A second ack leaves irq=0.
- Collisions: W1C on STATUS coinciding with a match leaves PEND=1. A COUNT write of 5 on a tick cycle reads back 5.
- Assert rst low mid-count with CMP=100 and COUNT=50 → everything 0 immediately; no irq after rst is released until EN is rewritten.
